fp_add_pipe: RTL and testbench

//  Parametrised, pipelined IEEE-754-style floating-point adder/subtractor; successor to the

---
 rtl/fp_add_pipe.sv | 210 +++++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_pipe.sv
// Pipelined floating-point adder/subtractor with round-to-nearest-even,
// flush-to-zero, special-value handling and a valid/ready handshake.
// Stage 1 unpacks/swaps/aligns, stage 2 adds/subtracts, stage 3
// normalises/rounds/packs into the output registers.
module fp_add_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   c,
  output logic [3:0]             flags
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam int M = MAN_W + 4;   // {hidden, frac, G, R, S}
  localparam int E = EXP_W + 2;   // internal exponent width
  localparam logic [W-1:0] QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [E-1:0] ALIGN_MAX = E'(MAN_W + 3);
  localparam logic [E-1:0] EXP_ONE   = E'(1);
  localparam logic [E-1:0] EXP_INF   = E'((1 << EXP_W) - 1);

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------- stage 1 ----------------
  logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic             eff_sub, swap, x_sign, y_zero;
  logic [EXP_W-1:0] ea, eb, x_exp, y_exp;
  logic [MAN_W-1:0] fa, fb, x_frac, y_frac;
  logic [E-1:0]     d;
  logic [M-1:0]     mx, my, my_al;
  logic [2*M-1:0]   wide;
  logic             spec;
  logic [W-1:0]     spec_c;
  logic [3:0]       spec_f;

  logic             s1_valid, s1_sign, s1_sub, s1_spec;
  logic [E-1:0]     s1_exp;
  logic [M-1:0]     s1_mx, s1_my;
  logic [W-1:0]     s1_spec_c;
  logic [3:0]       s1_spec_f;

  // Unpack, classify, order by magnitude and align the smaller operand.
  always_comb begin
    sa = a[W-1];
    ea = a[W-2:MAN_W];
    fa = a[MAN_W-1:0];
    sb = b[W-1] ^ op;
    eb = b[W-2:MAN_W];
    fb = b[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);
    eff_sub = sa ^ sb;
    swap = (b_zero ? '0 : b[W-2:0]) > (a_zero ? '0 : a[W-2:0]);
    if (swap) begin
      x_sign = sb; x_exp = eb; x_frac = fb;
      y_exp  = ea; y_frac = fa; y_zero = a_zero;
    end else begin
      x_sign = sa; x_exp = ea; x_frac = fa;
      y_exp  = eb; y_frac = fb; y_zero = b_zero;
    end
    mx   = {1'b1, x_frac, 3'b000};
    my   = y_zero ? '0 : {1'b1, y_frac, 3'b000};
    d    = {2'b00, x_exp} - {2'b00, y_exp};
    wide = {my, {M{1'b0}}} >> d;
    if (d >= ALIGN_MAX) my_al = {{(M-1){1'b0}}, |my};
    else                my_al = {wide[2*M-1:M+1], wide[M] | (|wide[M-1:0])};

    spec   = 1'b0;
    spec_c = '0;
    spec_f = '0;
    if (a_nan || b_nan) begin
      spec = 1'b1; spec_c = QNAN;
    end else if (a_inf && b_inf) begin
      spec = 1'b1;
      if (eff_sub) begin
        spec_c = QNAN; spec_f = 4'b1000;
      end else begin
        spec_c = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
    end else if (a_inf) begin
      spec = 1'b1; spec_c = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spec = 1'b1; spec_c = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      spec = 1'b1; spec_c = {sa & sb, {(W-1){1'b0}}};
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_sign   <= x_sign;
      s1_sub    <= eff_sub;
      s1_exp    <= {2'b00, x_exp};
      s1_mx     <= mx;
      s1_my     <= my_al;
      s1_spec   <= spec;
      s1_spec_c <= spec_c;
      s1_spec_f <= spec_f;
    end
  end

  // ---------------- stage 2 ----------------
  logic [M:0]   sum;
  logic         s2_valid, s2_sign, s2_spec;
  logic [E-1:0] s2_exp;
  logic [M:0]   s2_sum;
  logic [W-1:0] s2_spec_c;
  logic [3:0]   s2_spec_f;

  // Magnitude add or subtract; X is never smaller than aligned Y.
  always_comb begin
    if (s1_sub) sum = {1'b0, s1_mx} - {1'b0, s1_my};
    else        sum = {1'b0, s1_mx} + {1'b0, s1_my};
  end

  // Stage 2 register; exact cancellation forces a positive sign.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (adv) begin
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign & (sum != '0);
      s2_exp    <= s1_exp;
      s2_sum    <= sum;
      s2_spec   <= s1_spec;
      s2_spec_c <= s1_spec_c;
      s2_spec_f <= s1_spec_f;
    end
  end

  // ---------------- stage 3 ----------------
  logic [E-1:0]     lzc, exp_n, exp_r;
  logic [M-1:0]     norm;
  logic [MAN_W+1:0] mant;
  logic [MAN_W-1:0] frac_r;
  logic             rnd, inexact, unf;
  logic [W-1:0]     c_nx;
  logic [3:0]       f_nx;

  // Normalise, round to nearest even, then apply range and special overrides.
  always_comb begin
    lzc = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (s2_sum[i]) lzc = E'(M - 1 - i);
    end
    if (s2_sum[M]) begin
      norm  = {s2_sum[M:2], s2_sum[1] | s2_sum[0]};
      exp_n = s2_exp + EXP_ONE;
    end else begin
      norm  = s2_sum[M-1:0] << lzc;
      exp_n = s2_exp - lzc;
    end
    rnd     = norm[2] & (norm[1] | norm[0] | norm[3]);
    inexact = |norm[2:0];
    mant    = {1'b0, norm[M-1:3]} + {{(MAN_W+1){1'b0}}, rnd};
    exp_r   = mant[MAN_W+1] ? exp_n + EXP_ONE : exp_n;
    frac_r  = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
    unf     = exp_n[E-1] || (exp_n == '0);

    c_nx = {s2_sign, exp_r[EXP_W-1:0], frac_r};
    f_nx = {3'b000, inexact};
    if (s2_spec) begin
      c_nx = s2_spec_c;
      f_nx = s2_spec_f;
    end else if (s2_sum == '0) begin
      c_nx = '0;
      f_nx = '0;
    end else if (unf) begin
      c_nx = {s2_sign, {(W-1){1'b0}}};
      f_nx = 4'b0011;
    end else if (exp_r >= EXP_INF) begin
      c_nx = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      f_nx = 4'b0101;
    end
  end

  // Output register; c/flags only change when a valid result lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      c         <= '0;
      flags     <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        c     <= c_nx;
        flags <= f_nx;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Self-checking bench for fp_add_pipe (half precision): directed vector
// table, stall and reset sequences, and a randomized stream scored against
// an exact-arithmetic reference model.
module tb_fp_add_pipe;

  logic        clk, rst, in_valid, in_ready, op, out_valid, out_ready;
  logic [15:0] a, b, c;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [19:0] exp_q[$];
  logic [19:0] sb_e;

  fp_add_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  // Exact reference: values as integers in units of 2^-24, rounded by hand.
  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y, input logic sub);
    logic   sx, sy, sr, inx;
    int     ex, ey, fx, fy, p, e, sh;
    longint vx, vy, s, mag, m, rem, half;
    sx = x[15]; sy = y[15] ^ sub;
    ex = int'(x[14:10]); fx = int'(x[9:0]);
    ey = int'(y[14:10]); fy = int'(y[9:0]);
    if ((ex == 31 && fx != 0) || (ey == 31 && fy != 0)) return {16'h7E00, 4'b0000};
    if (ex == 31 && ey == 31)
      return (sx != sy) ? {16'h7E00, 4'b1000} : {sx, 15'h7C00, 4'b0000};
    if (ex == 31) return {sx, 15'h7C00, 4'b0000};
    if (ey == 31) return {sy, 15'h7C00, 4'b0000};
    vx = (ex == 0) ? 64'sd0 : (longint'(1024 + fx) << (ex - 1));
    vy = (ey == 0) ? 64'sd0 : (longint'(1024 + fy) << (ey - 1));
    if (vx == 0 && vy == 0) return {sx & sy, 15'h0000, 4'b0000};
    s = (sx ? -vx : vx) + (sy ? -vy : vy);
    if (s == 0) return 20'h0;
    sr  = (s < 0);
    mag = sr ? -s : s;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    e = p - 9;
    if (e <= 0) return {sr, 15'h0000, 4'b0011};
    inx = 1'b0;
    m   = mag;
    if (p > 10) begin
      sh   = p - 10;
      m    = mag >> sh;
      rem  = mag - (m << sh);
      half = longint'(1) << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && m[0])) m++;
      if (m == 2048) begin
        m = 1024;
        e++;
      end
    end
    if (e >= 31) return {sr, 15'h7C00, 4'b0101};
    return {sr, 5'(e), 10'(m - 1024), 3'b000, inx};
  endfunction

  function automatic logic [15:0] rnd_operand(input logic [15:0] other);
    case ($urandom_range(0, 4))
      0: return 16'($urandom);
      1: return other ^ 16'($urandom_range(0, 15));
      2: return {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
      3: return {1'($urandom), 5'($urandom_range(27, 30)), 10'($urandom)};
      default: begin
        case ($urandom_range(0, 7))
          0: return 16'h0000;
          1: return 16'h8000;
          2: return 16'h7C00;
          3: return 16'hFC00;
          4: return 16'h7E00;
          5: return 16'h7D01;
          6: return 16'h0001;
          default: return 16'h0400;
        endcase
      end
    endcase
  endfunction

  // Scoreboard: transfers are sampled mid-cycle, ahead of the edge that commits them.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_output", 32'd1, 32'd0);
        end else begin
          sb_e = exp_q.pop_front();
          chk("sb_c", 32'(c), 32'(sb_e[19:4]));
          chk("sb_flags", 32'(flags), 32'(sb_e[3:0]));
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, op));
    end
  end

  // One operation on an idle pipe, checking latency and the expected result.
  task automatic run_vec(input string name, input logic [15:0] va, input logic [15:0] vb,
                         input logic vop, input logic [15:0] ec, input logic [3:0] ef);
    int lat;
    a = va; b = vb; op = vop; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'd3);
    chk({name, "_c"}, 32'(c), 32'(ec));
    chk({name, "_flags"}, 32'(flags), 32'(ef));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [15:0] c;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs [17];
  logic [15:0] sa_ops [8];
  logic [15:0] sb_ops [8];
  logic [19:0] hold;

  initial begin
    int sent, base, cnt;
    logic acc;

    vecs[0]  = '{16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000};
    vecs[1]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000};
    vecs[2]  = '{16'h8000, 16'h0000, 1'b0, 16'h0000, 4'b0000};
    vecs[3]  = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0001};
    vecs[4]  = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'b0001};
    vecs[5]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101};
    vecs[6]  = '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b1000};
    vecs[7]  = '{16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'b0000};
    vecs[8]  = '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 4'b0000};
    vecs[9]  = '{16'h3C00, 16'hFC00, 1'b1, 16'h7C00, 4'b0000};
    vecs[10] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0000};
    vecs[11] = '{16'h0400, 16'h0401, 1'b1, 16'h8000, 4'b0011};
    vecs[12] = '{16'h0001, 16'h3C00, 1'b0, 16'h3C00, 4'b0000};
    vecs[13] = '{16'h4000, 16'h3C00, 1'b1, 16'h3C00, 4'b0000};
    vecs[14] = '{16'h3C00, 16'h0C00, 1'b0, 16'h3C00, 4'b0001};
    vecs[15] = '{16'h3E00, 16'h3E00, 1'b0, 16'h4200, 4'b0000};
    vecs[16] = '{16'h7BFF, 16'h5000, 1'b0, 16'h7C00, 4'b0101};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_c", 32'(c), 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].c, vecs[i].f);

    // Back-to-back stream with a three-cycle sink stall in the middle.
    for (int i = 0; i < 8; i++) begin
      sa_ops[i] = rnd_operand(16'h3C00);
      sb_ops[i] = rnd_operand(sa_ops[i]);
    end
    sa_ops[1] = 16'h3C00; sb_ops[1] = 16'h4000;
    base = n_out;
    sent = 0;
    hold = '0;
    for (int k = 0; k < 40 && sent < 8; k++) begin
      in_valid  = 1'b1;
      a = sa_ops[sent]; b = sb_ops[sent]; op = sent[0];
      out_ready = !(k >= 4 && k <= 6);
      #1;
      if (k >= 4 && k <= 6) begin
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        if (k == 4) hold = {c, flags};
        else        chk("stall_hold", 32'({c, flags}), 32'(hold));
      end
      if (k == 7) chk("stall_hold_release", 32'({c, flags}), 32'(hold));
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    while ((n_out - base) < 8 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("stream_sent", 32'(sent), 32'd8);
    chk("stream_received", 32'(n_out - base), 32'd8);
    chk("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset with three operations inside the pipe.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; a = 16'h3C00; b = 16'h4000; op = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_c", 32'(c), 32'd0);
    chk("midreset_flags", 32'(flags), 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midreset_no_ghost", 32'(out_valid), 32'd0);
    run_vec("post_reset", 16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000);

    // Randomized traffic with random sink back-pressure.
    acc = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a  = rnd_operand(16'h3C00);
        b  = rnd_operand(a);
        op = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 4) != 0);
      #1;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("random_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
